async_fifo: RTL and testbench

ASYNC_FIFO -- requirements
Module: async_fifo

---
 rtl/async_fifo.sv | 75 +++++++
 tb/tb_async_fifo.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/async_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy counter.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module async_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  CLK,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    output logic                  wr_rdy,
    output logic                  full,
    input  logic                  rd_en,
    output logic                  rd_rdy,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] COUNT_ONE  = (AW+1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wrPtr_q, wrPtr_d;
    logic [AW-1:0]         rdPtr_q, rdPtr_d;
    logic [AW:0]           count_q, count_d;
    logic                  wrAccept;
    logic                  rdAccept;

    // Flags come only from the registered count, so ready never depends on wr_en/rd_en.
    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign wr_rdy   = ~full;
    assign rd_rdy   = ~empty;
    assign wrAccept = wr_en & wr_rdy;
    assign rdAccept = rd_en & rd_rdy;
    assign dout     = empty ? '0 : mem_q[rdPtr_q];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (wrAccept) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (rdAccept) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (wrAccept && !rdAccept) begin
            count_d = count_q + COUNT_ONE;
        end else if (rdAccept && !wrAccept) begin
            count_d = count_q - COUNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is not cleared on reset; the zeroed count makes old contents unreachable.
    always_ff @(posedge CLK) begin
        if (reset_n && wrAccept) begin
            mem_q[wrPtr_q] <= din;
        end
    end

endmodule

// File: tb/tb_async_fifo.sv
// Directed self-checking bench for async_fifo (DEPTH=16, DATA_WIDTH=32).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_async_fifo;

    logic        CLK;
    logic        reset_n;
    logic [31:0] din;
    logic        wr_en;
    logic        wr_rdy;
    logic        full;
    logic        rd_en;
    logic        rd_rdy;
    logic        empty;
    logic [31:0] dout;

    int testCount;
    int failCount;

    async_fifo #(
        .DATA_WIDTH(32),
        .DEPTH(16)
    ) dut (
        .CLK(CLK),
        .reset_n(reset_n),
        .din(din),
        .wr_en(wr_en),
        .wr_rdy(wr_rdy),
        .full(full),
        .rd_en(rd_en),
        .rd_rdy(rd_rdy),
        .empty(empty),
        .dout(dout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one cycle of inputs, then return just after the edge that consumes them.
    task automatic applyStimulus(input logic wr, input logic [31:0] data,
                                 input logic rd, input logic rstN);
        wr_en   = wr;
        din     = data;
        rd_en   = rd;
        reset_n = rstN;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkFlags(input string tag, input logic expEmpty, input logic expFull);
        checkOutput({tag, " empty"}, {31'd0, empty}, {31'd0, expEmpty});
        checkOutput({tag, " full"}, {31'd0, full}, {31'd0, expFull});
        checkOutput({tag, " wr_rdy"}, {31'd0, wr_rdy}, {31'd0, ~expFull});
        checkOutput({tag, " rd_rdy"}, {31'd0, rd_rdy}, {31'd0, ~expEmpty});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testCount = 0;
        failCount = 0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        din       = '0;
        reset_n   = 1'b0;
        #1;

        // Reset held for two edges
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkFlags("reset", 1'b1, 1'b0);
        checkOutput("reset dout", dout, 32'h0);

        // Ten writes then ten reads, in order
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b0, 1'b1);
            if (i == 0) begin
                checkOutput("first word latency", dout, 32'h0);
                checkFlags("after first write", 1'b0, 1'b0);
            end
        end
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("seq10 dout[%0d]", i), dout, 32'(i));
            checkOutput($sformatf("seq10 rd_rdy[%0d]", i), {31'd0, rd_rdy}, 32'd1);
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        end
        checkFlags("seq10 drained", 1'b1, 1'b0);
        checkOutput("seq10 drained dout", dout, 32'h0);

        // Fill to 16, refused overflow write, then read+write while full
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b1);
            if (i == 14) checkFlags("fill 15", 1'b0, 1'b0);
        end
        checkFlags("fill 16", 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b1);
        checkFlags("overflow ignored", 1'b0, 1'b1);
        checkOutput("overflow head", dout, 32'h100);
        applyStimulus(1'b1, 32'hBEEF, 1'b1, 1'b1);
        checkFlags("full rd+wr", 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) begin
            checkOutput($sformatf("full drain[%0d]", i), dout, 32'h100 + 32'(i));
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        end
        checkFlags("full drained", 1'b1, 1'b0);
        checkOutput("full drained dout", dout, 32'h0);

        // Steady state at count 10 with simultaneous push/pop across pointer wrap
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            checkOutput($sformatf("stream head[%0d]", k), dout,
                        (k < 10) ? 32'h200 + 32'(k) : 32'h300 + 32'(k - 10));
            applyStimulus(1'b1, 32'h300 + 32'(k), 1'b1, 1'b1);
            checkOutput($sformatf("stream flags[%0d]", k), {30'd0, empty, full}, 32'h0);
        end
        for (int k = 20; k < 30; k++) begin
            checkOutput($sformatf("stream tail[%0d]", k), dout, 32'h300 + 32'(k - 10));
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        end
        checkFlags("stream drained", 1'b1, 1'b0);

        // Underflow attempts, then write with concurrent read on empty
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkFlags("underflow ignored", 1'b1, 1'b0);
        checkOutput("underflow dout", dout, 32'h0);
        applyStimulus(1'b1, 32'h5A, 1'b1, 1'b1);
        checkFlags("empty wr+rd", 1'b0, 1'b0);
        checkOutput("0x5A visible", dout, 32'h5A);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkFlags("0x5A popped", 1'b1, 1'b0);

        // Reset mid-operation with a concurrent write discards everything
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h400 + 32'(i), 1'b0, 1'b1);
        checkOutput("pre-reset head", dout, 32'h400);
        applyStimulus(1'b1, 32'hABCD, 1'b1, 1'b0);
        checkFlags("mid reset", 1'b1, 1'b0);
        checkOutput("mid reset dout", dout, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkFlags("post reset read refused", 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h77, 1'b0, 1'b1);
        checkOutput("post reset write", dout, 32'h77);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkFlags("post reset drained", 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
